// File: rtl/audio_pkg.sv
// audio_pkg: shared FSM state encoding and default sample width for the AXI-stream/I2S bridges.
// Contents:
//   WORD_LENGTH_DEFAULT - default bits per channel sample
//   state_t             - 3-bit state type: INIT=0, IDLE=1, SEND_L=2, SEND_R=3, SYNC=4
package audio_pkg;
    localparam int WORD_LENGTH_DEFAULT = 16;
    typedef enum logic [2:0] {
        INIT   = 3'd0,
        IDLE   = 3'd1,
        SEND_L = 3'd2,
        SEND_R = 3'd3,
        SYNC   = 3'd4
    } state_t;
endpackage

// File: rtl/i2s_clk_edge_det.sv
// i2s_clk_edge_det: registered one-cycle pulse on each falling edge of the I2S bit clock.
// Ports:
//   clk     in  - system clock
//   rst     in  - synchronous active-high reset
//   clk_i2s in  - I2S bit clock, sampled as data
//   fall    out - pulse asserted in the cycle after clk first samples clk_i2s low
module i2s_clk_edge_det (
    input  logic clk,
    input  logic rst,
    input  logic clk_i2s,
    output logic fall
);
    logic r_clk_i2s_d;
    logic r_fall;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_clk_i2s_d <= 1'b0;
            r_fall      <= 1'b0;
        end else begin
            r_clk_i2s_d <= clk_i2s;
            r_fall      <= r_clk_i2s_d & ~clk_i2s;
        end
    end

    assign fall = r_fall;
endmodule

// File: rtl/axis_master_if.sv
// axis_master_if: accepts a stereo frame from the I2S receiver and emits it as AXI-stream beats.
// Optional feature macro: AXIS_MASTER_MONO_EN (one averaged beat per frame instead of L then R).
// Ports:
//   clk, rst    in  - system clock, synchronous active-high reset
//   clk_i2s     in  - I2S bit clock; its falling edge re-arms frame acceptance
//   i2s_data    in  - stereo frame, left in upper half, right in lower half
//   i2s_valid   in  - frame available
//   i2s_ready   out - block can accept a frame
//   axis_data   out - AXI-stream sample
//   axis_valid  out - AXI-stream valid
//   axis_ready  in  - AXI-stream ready
//   axis_last   out - final beat of a frame
//   drop_count  out - saturating count of frames missed while busy
module axis_master_if
    import audio_pkg::*;
#(
    parameter int WORD_LENGTH = WORD_LENGTH_DEFAULT
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     clk_i2s,
    input  logic [2*WORD_LENGTH-1:0] i2s_data,
    input  logic                     i2s_valid,
    output logic                     i2s_ready,
    output logic [WORD_LENGTH-1:0]   axis_data,
    output logic                     axis_valid,
    input  logic                     axis_ready,
    output logic                     axis_last,
    output logic [7:0]               drop_count
);
    state_t                 r_state;
    logic                   r_i2s_ready;
    logic [WORD_LENGTH-1:0] r_axis_data;
    logic                   r_axis_valid;
    logic                   r_axis_last;
    logic [7:0]             r_drop_count;
    logic                   w_fall;
    logic                   w_busy;

    i2s_clk_edge_det u_edge (
        .clk     (clk),
        .rst     (rst),
        .clk_i2s (clk_i2s),
        .fall    (w_fall)
    );

    assign w_busy = (r_state != IDLE) && (r_state != INIT);

`ifdef AXIS_MASTER_MONO_EN
    // Sign-extend both channels so the sum cannot overflow; >>> floors toward -inf.
    logic signed [WORD_LENGTH:0] w_sum;
    assign w_sum = $signed({i2s_data[2*WORD_LENGTH-1], i2s_data[2*WORD_LENGTH-1:WORD_LENGTH]})
                 + $signed({i2s_data[WORD_LENGTH-1], i2s_data[WORD_LENGTH-1:0]});
`else
    logic [WORD_LENGTH-1:0] r_right;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= INIT;
            r_i2s_ready  <= 1'b0;
            r_axis_data  <= '0;
            r_axis_valid <= 1'b0;
            r_axis_last  <= 1'b0;
            r_drop_count <= 8'd0;
`ifndef AXIS_MASTER_MONO_EN
            r_right      <= '0;
`endif
        end else begin
            if (w_fall && w_busy && i2s_valid && r_drop_count != 8'hFF)
                r_drop_count <= r_drop_count + 8'd1;
            case (r_state)
                INIT: begin
                    r_i2s_ready <= 1'b1;
                    r_state     <= IDLE;
                end
                IDLE: begin
                    if (i2s_valid && r_i2s_ready) begin
                        r_i2s_ready  <= 1'b0;
                        r_axis_valid <= 1'b1;
`ifdef AXIS_MASTER_MONO_EN
                        r_axis_data  <= WORD_LENGTH'(w_sum >>> 1);
                        r_axis_last  <= 1'b1;
                        r_state      <= SEND_R;
`else
                        r_axis_data  <= i2s_data[2*WORD_LENGTH-1:WORD_LENGTH];
                        r_right      <= i2s_data[WORD_LENGTH-1:0];
                        r_axis_last  <= 1'b0;
                        r_state      <= SEND_L;
`endif
                    end
                end
                SEND_L: begin
`ifndef AXIS_MASTER_MONO_EN
                    if (axis_ready) begin
                        r_axis_data <= r_right;
                        r_axis_last <= 1'b1;
                        r_state     <= SEND_R;
                    end
`else
                    r_state <= SEND_R;
`endif
                end
                SEND_R: begin
                    if (axis_ready) begin
                        r_axis_valid <= 1'b0;
                        r_axis_last  <= 1'b0;
                        r_state      <= SYNC;
                    end
                end
                SYNC: begin
                    // fall is only sampled once already in SYNC, so a pulse coinciding with entry is skipped
                    if (w_fall) begin
                        r_i2s_ready <= 1'b1;
                        r_state     <= IDLE;
                    end
                end
                default: r_state <= INIT;
            endcase
        end
    end

    assign i2s_ready  = r_i2s_ready;
    assign axis_data  = r_axis_data;
    assign axis_valid = r_axis_valid;
    assign axis_last  = r_axis_last;
    assign drop_count = r_drop_count;
endmodule

// File: tb/tb_axis_master_if.sv
// tb_axis_master_if: directed self-checking bench for axis_master_if.
module tb_axis_master_if;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        clk_i2s = 1'b0;
    logic [31:0] i2s_data = 32'h0;
    logic        i2s_valid = 1'b0;
    logic        i2s_ready;
    logic [15:0] axis_data;
    logic        axis_valid;
    logic        axis_ready = 1'b0;
    logic        axis_last;
    logic [7:0]  drop_count;
    int          n_checks = 0;
    int          n_fail = 0;

    axis_master_if #(.WORD_LENGTH(16)) dut (
        .clk        (clk),
        .rst        (rst),
        .clk_i2s    (clk_i2s),
        .i2s_data   (i2s_data),
        .i2s_valid  (i2s_valid),
        .i2s_ready  (i2s_ready),
        .axis_data  (axis_data),
        .axis_valid (axis_valid),
        .axis_ready (axis_ready),
        .axis_last  (axis_last),
        .drop_count (drop_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    // One clk_i2s period; afterwards the resulting fall pulse has been consumed by the FSM.
    task automatic i2s_fall();
        clk_i2s = 1'b1;
        repeat (2) tick();
        clk_i2s = 1'b0;
        repeat (2) tick();
    endtask

    initial begin
        repeat (3) tick();
        chk("rst_ready", {31'b0, i2s_ready}, 32'd0);
        chk("rst_valid", {31'b0, axis_valid}, 32'd0);
        chk("rst_last", {31'b0, axis_last}, 32'd0);
        chk("rst_data", {16'b0, axis_data}, 32'd0);
        chk("rst_drop", {24'b0, drop_count}, 32'd0);
        rst = 1'b0;
        tick();
        chk("ready_after_rst", {31'b0, i2s_ready}, 32'd1);
`ifdef AXIS_MASTER_MONO_EN
        i2s_data = 32'h7FFF_0001; i2s_valid = 1'b1; axis_ready = 1'b1;
        tick();
        i2s_valid = 1'b0;
        chk("mono1_data", {16'b0, axis_data}, 32'h4000);
        chk("mono1_last", {31'b0, axis_last}, 32'd1);
        chk("mono1_valid", {31'b0, axis_valid}, 32'd1);
        tick();
        chk("mono1_done", {31'b0, axis_valid}, 32'd0);
        i2s_fall();
        chk("mono_rearm", {31'b0, i2s_ready}, 32'd1);
        i2s_data = 32'h8000_FFFF; i2s_valid = 1'b1;
        tick();
        i2s_valid = 1'b0;
        chk("mono2_data", {16'b0, axis_data}, 32'hBFFF);
        chk("mono2_last", {31'b0, axis_last}, 32'd1);
        tick();
        chk("mono2_done", {31'b0, axis_valid}, 32'd0);
`else
        // Back-to-back frame
        i2s_data = 32'h1234_ABCD; i2s_valid = 1'b1; axis_ready = 1'b1;
        tick();
        i2s_valid = 1'b0;
        chk("f1_l_data", {16'b0, axis_data}, 32'h1234);
        chk("f1_l_last", {31'b0, axis_last}, 32'd0);
        chk("f1_l_valid", {31'b0, axis_valid}, 32'd1);
        chk("f1_ready_low", {31'b0, i2s_ready}, 32'd0);
        tick();
        chk("f1_r_data", {16'b0, axis_data}, 32'hABCD);
        chk("f1_r_last", {31'b0, axis_last}, 32'd1);
        chk("f1_r_valid", {31'b0, axis_valid}, 32'd1);
        tick();
        chk("f1_done_valid", {31'b0, axis_valid}, 32'd0);
        chk("f1_done_last", {31'b0, axis_last}, 32'd0);
        clk_i2s = 1'b1;
        repeat (2) tick();
        chk("sync_wait", {31'b0, i2s_ready}, 32'd0);
        clk_i2s = 1'b0;
        tick();
        chk("sync_fall_cycle", {31'b0, i2s_ready}, 32'd0);
        tick();
        chk("sync_rearm", {31'b0, i2s_ready}, 32'd1);
        // Stalled frame
        axis_ready = 1'b0; i2s_valid = 1'b1;
        tick();
        i2s_valid = 1'b0;
        for (int i = 0; i < 5; i++) begin
            clk_i2s = (i == 0) ? 1'b1 : (i == 2) ? 1'b0 : clk_i2s;
            chk("stall_l_data", {16'b0, axis_data}, 32'h1234);
            chk("stall_l_last", {31'b0, axis_last}, 32'd0);
            chk("stall_l_valid", {31'b0, axis_valid}, 32'd1);
            tick();
        end
        chk("stall_drop", {24'b0, drop_count}, 32'd0);
        axis_ready = 1'b1;
        tick();
        axis_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            chk("stall_r_data", {16'b0, axis_data}, 32'hABCD);
            chk("stall_r_last", {31'b0, axis_last}, 32'd1);
            chk("stall_r_valid", {31'b0, axis_valid}, 32'd1);
            tick();
        end
        axis_ready = 1'b1;
        tick();
        chk("stall_done", {31'b0, axis_valid}, 32'd0);
        i2s_fall();
        chk("stall_rearm", {31'b0, i2s_ready}, 32'd1);
        chk("stall_drop2", {24'b0, drop_count}, 32'd0);
        // Drop counter saturation while stuck in SEND_L
        axis_ready = 1'b0; i2s_data = 32'h1111_2222; i2s_valid = 1'b1;
        tick();
        for (int i = 0; i < 100; i++) i2s_fall();
        chk("drop_100", {24'b0, drop_count}, 32'd100);
        for (int i = 0; i < 200; i++) i2s_fall();
        chk("drop_sat", {24'b0, drop_count}, 32'd255);
        chk("drop_hold_data", {16'b0, axis_data}, 32'h1111);
        chk("drop_hold_valid", {31'b0, axis_valid}, 32'd1);
        // Reset mid-frame in SEND_L
        rst = 1'b1;
        tick();
        chk("midrst_valid", {31'b0, axis_valid}, 32'd0);
        chk("midrst_drop", {24'b0, drop_count}, 32'd0);
        chk("midrst_ready", {31'b0, i2s_ready}, 32'd0);
        i2s_data = 32'h5555_6666; axis_ready = 1'b1;
        rst = 1'b0;
        tick();
        chk("post_rst_ready", {31'b0, i2s_ready}, 32'd1);
        chk("post_rst_idle", {31'b0, axis_valid}, 32'd0);
        tick();
        i2s_valid = 1'b0;
        chk("post_rst_l", {16'b0, axis_data}, 32'h5555);
        chk("post_rst_l_last", {31'b0, axis_last}, 32'd0);
        tick();
        chk("post_rst_r", {16'b0, axis_data}, 32'h6666);
        chk("post_rst_r_last", {31'b0, axis_last}, 32'd1);
        tick();
        chk("post_rst_done", {31'b0, axis_valid}, 32'd0);
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/axis_master_if.md
# axis_master_if

Receive-path counterpart of the AXI-stream-to-I2S slave interface. Accepts one stereo frame (left and right, packed) from the I2S receiver through a valid/ready handshake. Emits the frame as AXI-stream beats on the `clk` domain, left then right, with `axis_last` on the final beat. The next frame is re-armed only after a falling edge of `clk_i2s`, which keeps frame acceptance aligned to the I2S bit clock.

## Interface
- `WORD_LENGTH`, default 16: bits per channel sample; two's-complement.
- `clk`  in  1: system clock; all logic on its rising edge.
- `rst`  in  1: synchronous, active-high reset; has priority over all other logic.
- `clk_i2s`  in  1: I2S bit clock, sampled as data on `clk` and used only for edge detection.
- `i2s_data`  in  2*WORD_LENGTH: stereo frame; bits [2W-1:W] are left, bits [W-1:0] are right.
- `i2s_valid`  in  1: frame available from the I2S receiver.
- `i2s_ready`  out  1: block can accept a frame.
- `axis_data`  out  WORD_LENGTH: AXI-stream sample.
- `axis_valid`  out  1: AXI-stream valid.
- `axis_ready`  in  1: AXI-stream ready from the downstream consumer.
- `axis_last`  out  1: final beat of a frame.
- `drop_count`  out  8: saturating count of frames missed while the block was busy.

## Operation
- Handshakes:
  - Transfers complete on `i2s_valid & i2s_ready` (frame transfer) and on `axis_valid & axis_ready` (beat transfer).
- Edge detect:
  - `clk_i2s_d <= clk_i2s`.
  - `fall <= clk_i2s_d & ~clk_i2s`.
  - `fall` is a one-cycle pulse, asserted in the cycle after the first `clk` edge that samples `clk_i2s` low.
- States:
  - INIT: `i2s_ready<=1`, go to IDLE.
  - IDLE: on a frame transfer, latch the frame, `i2s_ready<=0`, `axis_data<=left`, `axis_valid<=1`, `axis_last<=0`, go to SEND_L.
  - SEND_L: on a beat transfer, `axis_data<=right`, `axis_last<=1`, go to SEND_R.
  - SEND_R: on a beat transfer, `axis_valid<=0`, `axis_last<=0`, go to SYNC.
  - SYNC: on `fall`, `i2s_ready<=1`, go to IDLE. If `fall` arrives in the same cycle as SYNC is entered, it is not seen; the block waits for the next falling edge.
- AXI-stream rules:
  - `axis_data` and `axis_last` hold stable while `axis_valid & ~axis_ready`.
  - `axis_valid` never drops without a beat transfer.
  - Back-to-back beats are allowed; with `axis_ready` held high, L and R go out in consecutive cycles.
- Drop counter:
  - Increments by 1 in any cycle where `fall` is high, state is not IDLE or INIT, and `i2s_valid` is high.
  - Saturates at 255 and clears only on `rst`.
- Reset values: `i2s_ready=0`, `axis_valid=0`, `axis_last=0`, `axis_data=0`, `drop_count=0`, state INIT, `clk_i2s_d=0`, `fall=0`.
- Reset mid-frame: the frame in flight is discarded and no further beats are emitted. `axis_valid` is low in the cycle after the reset edge.

## Timing
- `i2s_ready` rises one cycle after `rst` deasserts (INIT → IDLE).
- Frame transfer at edge t: `axis_valid` high from t+1. `i2s_ready` is low from t+1, so no second frame is accepted at t+1.
- Best-case frame turnaround: 1 cycle to capture, 2 beat cycles, then SYNC until `fall`, then 1 cycle to re-arm.
- `fall` lags the `clk_i2s` falling edge by 1–2 `clk` cycles. `clk` must be at least 4× `clk_i2s`.

## Configuration
- `AXIS_MASTER_MONO_EN`
  - Defined: IDLE loads `axis_data <= (L + R) >>> 1`. The sum is computed at WORD_LENGTH+1 bits, signed, with arithmetic shift and truncation toward −∞. `axis_last<=1` and the next state is SEND_R, so one beat is sent per frame.
  - Undefined: two beats per frame as described in Operation; mono logic is absent.

## Structure
- Package `audio_pkg`: state localparams (INIT=0, IDLE=1, SEND_L=2, SEND_R=3, SYNC=4; 3-bit state type) and the default `WORD_LENGTH`. These are shared with `axis_slave_if`.
- Sub-module `i2s_clk_edge_det`: registered falling-edge pulse of `clk_i2s`, with the `clk`/`rst` ports. It is reusable by the slave side.

## Test plan
- Reset release, `i2s_valid=0`: all outputs 0 during reset; `i2s_ready=1` exactly 1 cycle after `rst` falls.
- Frame 0x1234_ABCD with `axis_ready=1`: beats 0x1234 (last=0), then 0xABCD (last=1) in consecutive cycles; `i2s_ready` returns one cycle after `fall`.
- Same frame, `axis_ready` low for 5 cycles on each beat: data and last held stable and no beat lost; `drop_count` unchanged while `i2s_valid=0`.
- `i2s_valid` held high with `axis_ready=0` across 300 `clk_i2s` falls: `drop_count` saturates at 255; `rst` clears it to 0.
- `rst` asserted in SEND_L: `axis_valid=0` the next cycle; after release the first beat is the new frame's left sample.
- With `AXIS_MASTER_MONO_EN`, frame L=0x7FFF, R=0x0001: one beat 0x4000, last=1. Frame L=0x8000, R=0xFFFF: one beat 0xBFFF.
